// File: rtl/ebpf_fetch_pkg.sv
// Shared types and constants for the eBPF instruction prefetch stage.
package ebpf_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int unsigned INSN_BYTES = 8;
  localparam int unsigned PC_MAX_W   = 64;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_RANGE    = 2'b10;

  typedef struct packed {
    logic [63:0]         data;
    logic [PC_MAX_W-1:0] pc;
    logic [1:0]          exc;
  } fetch_entry_t;

endpackage

// File: rtl/ebpf_sync_fifo.sv
// In-order queue with a registered head: pop_data only changes on pop, push into empty, or reset.
module ebpf_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = head_q;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      // The head register is refilled either straight from the input or from the next stored slot.
      if (count_q == '0 || (count_q == CNT_W'(1) && do_pop)) begin
        if (do_push) head_d = push_data;
      end else if (do_pop) begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone decide which slots are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/ebpf_fetch_queue.sv
// Sequential instruction prefetcher: credit-limited fetch issue, stale-response discard on
// redirect, and an in-order queue presenting {insn, pc, exc} to the core.
module ebpf_fetch_queue
  import ebpf_fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              stop,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [63:0]       imem_rsp_data,
  input  logic [1:0]        imem_rsp_exc,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [63:0]       insn_data,
  output logic [ADDR_W-1:0] insn_pc,
  output logic [1:0]        insn_exc,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OFS_W = $clog2(INSN_BYTES);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSN_BYTES);
  localparam logic [CNT_W:0]    CREDITS = (CNT_W + 1)'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic              flush, credit_ok, req_fire, rsp_accept, enq, deq;
  logic [ADDR_W-1:0] flush_pc;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  fetch_entry_t      push_entry, head_entry;

  assign flush    = start || redirect_valid;
  assign flush_pc = start ? {start_pc[ADDR_W-1:OFS_W], OFS_W'(0)}
                          : {redirect_pc[ADDR_W-1:OFS_W], OFS_W'(0)};

  // Requests in flight plus queued words never exceed DEPTH, so the queue cannot overflow.
  assign credit_ok      = !fifo_full &&
                          (({1'b0, outstanding_q} + {1'b0, fifo_count}) < CREDITS);
  assign imem_req_valid = (state_q == RUN) && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
  assign rsp_accept = imem_rsp_valid && (outstanding_q != '0);
  assign enq        = rsp_accept && (discard_q == '0) && !flush;
  assign deq        = insn_valid && insn_ready;

  assign push_entry = '{data: imem_rsp_data, pc: PC_MAX_W'(rsp_pc_q), exc: imem_rsp_exc};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_accept);

    if (flush) begin
      pc_d      = flush_pc;
      rsp_pc_d  = flush_pc;
      // Everything still in flight after this edge belongs to the old stream.
      discard_d = outstanding_d;
    end else begin
      if (req_fire) pc_d = pc_q + PC_STEP;
      if (enq) rsp_pc_d = rsp_pc_q + PC_STEP;
      if (rsp_accept && discard_q != '0) discard_d = discard_q - CNT_W'(1);
    end

    if (start) begin
      state_d = RUN;
    end else if (redirect_valid) begin
      if (state_q == FAULT) state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (stop) state_d = IDLE;
          else if (enq && imem_rsp_exc != EXC_NONE) state_d = FAULT;
        end
        IDLE, FAULT: state_d = state_q;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      rsp_pc_q      <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  ebpf_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (enq),
    .push_data (push_entry),
    .pop       (deq),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign insn_valid = !fifo_empty;
  assign insn_data  = head_entry.data;
  assign insn_pc    = head_entry.pc[ADDR_W-1:0];
  assign insn_exc   = head_entry.exc;
  assign busy       = (state_q != IDLE) || (outstanding_q != '0);

endmodule

// File: tb/tb_ebpf_fetch_queue.sv
// Directed bench for ebpf_fetch_queue: table of start/stream vectors plus hand-written
// backpressure, redirect, exception, stop and mid-run reset sequences against a latency model.
module tb_ebpf_fetch_queue;
  import ebpf_fetch_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_pc = '0;
  logic              stop = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              imem_req_valid;
  logic              imem_req_ready = 1'b1;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid = 1'b0;
  logic [63:0]       imem_rsp_data = '0;
  logic [1:0]        imem_rsp_exc = '0;
  logic              insn_valid;
  logic              insn_ready = 1'b1;
  logic [63:0]       insn_data;
  logic [ADDR_W-1:0] insn_pc;
  logic [1:0]        insn_exc;
  logic              busy;

  always #5 clk = ~clk;

  ebpf_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .start          (start),
    .start_pc       (start_pc),
    .stop           (stop),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_exc   (imem_rsp_exc),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn_data      (insn_data),
    .insn_pc        (insn_pc),
    .insn_exc       (insn_exc),
    .busy           (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mem_lat = 1;
  logic [63:0] exc_addr = 64'h1;
  int credit_sum;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;
  pend_t       pend_q[$];
  logic [63:0] hs_log[$];

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0F0F, ~a[31:0]};
  endfunction

  // Memory model: in-order responses, mem_lat cycles after the request handshake.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q[0].addr);
      imem_rsp_exc   = (pend_q[0].addr == exc_addr) ? EXC_RANGE : EXC_NONE;
      void'(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_exc   = '0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      pend_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      hs_log.push_back(imem_req_addr);
    end
    if (rst_n) begin
      credit_sum = int'(dut.outstanding_q) + int'(dut.u_fifo.count_q);
      if (credit_sum > int'(DEPTH)) begin
        n_fail++;
        $display("FAIL credit_overflow: in_flight+queued=%0d limit=%0d", credit_sum, DEPTH);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic get_insn(output logic [63:0] pc, output logic [63:0] data,
                          output logic [1:0] exc, output bit ok);
    ok = 1'b0; pc = '0; data = '0; exc = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (insn_valid && insn_ready) begin
        pc = insn_pc; data = insn_data; exc = insn_exc; ok = 1'b1;
        step();
        return;
      end
    end
  endtask

  task automatic expect_insn(input string name, input logic [63:0] exp_pc, input logic [1:0] exp_exc);
    logic [63:0] pc, data;
    logic [1:0]  exc;
    bit          ok;
    get_insn(pc, data, exc, ok);
    check({name, "_arrived"}, 64'(ok), 64'd1);
    if (ok) begin
      check({name, "_pc"}, pc, exp_pc);
      check({name, "_data"}, data, mem_word(exp_pc));
      check({name, "_exc"}, 64'(exc), 64'(exp_exc));
    end
  endtask

  task automatic drain();
    stop = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      step();
    end
    check("drain_busy", 64'(busy), 64'd0);
    step();
    stop = 1'b0;
  endtask

  typedef struct {
    logic [63:0] start_pc;
    int          lat;
    logic [63:0] exp_pc0;
    logic [63:0] exp_pc1;
    int          exp_first;
  } stream_vec_t;

  stream_vec_t vecs[4];

  initial begin
    int          first, base;
    logic [63:0] pc, data;
    logic [1:0]  exc;
    bit          ok;

    vecs[0] = '{64'h100,                 1, 64'h100,                 64'h108, 3};
    vecs[1] = '{64'h105,                 2, 64'h100,                 64'h108, 4};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF8, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,   3};
    vecs[3] = '{64'h2007,                3, 64'h2000,                64'h2008, 5};

    repeat (3) step();
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_insn_valid", 64'(insn_valid), 64'd0);
    check("rst_insn_data", insn_data, 64'd0);
    check("rst_insn_pc", insn_pc, 64'd0);
    check("rst_insn_exc", 64'(insn_exc), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    step();

    // Table-driven streams: alignment, wrap and first-valid latency per memory latency.
    for (int v = 0; v < 4; v++) begin
      drain();
      mem_lat  = vecs[v].lat;
      start_pc = vecs[v].start_pc;
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_req_valid", v), 64'(imem_req_valid), 64'd1);
      check($sformatf("v%0d_req_addr", v), imem_req_addr, vecs[v].exp_pc0);
      first = 0;
      for (int c = 1; c <= 20; c++) begin
        if (c > 1) @(negedge clk);
        if (insn_valid) begin
          first = c;
          break;
        end
        step();
      end
      check($sformatf("v%0d_first_latency", v), 64'(first), 64'(vecs[v].exp_first));
      check($sformatf("v%0d_i0_pc", v), insn_pc, vecs[v].exp_pc0);
      check($sformatf("v%0d_i0_data", v), insn_data, mem_word(vecs[v].exp_pc0));
      check($sformatf("v%0d_i0_exc", v), 64'(insn_exc), 64'(EXC_NONE));
      step();
      for (int i = 1; i < 4; i++)
        expect_insn($sformatf("v%0d_i%0d", v, i), vecs[v].exp_pc1 + 64'(8 * (i - 1)), EXC_NONE);
    end

    // Backpressure: with the core stalled exactly DEPTH fetches go out.
    drain();
    mem_lat = 1;
    insn_ready = 1'b0;
    base = hs_log.size();
    start_pc = 64'h100;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    @(negedge clk);
    #1;
    check("bp_req_count", 64'(hs_log.size() - base), 64'(DEPTH));
    check("bp_req_valid", 64'(imem_req_valid), 64'd0);
    check("bp_insn_valid", 64'(insn_valid), 64'd1);
    check("bp_insn_pc_stable", insn_pc, 64'h100);
    step();
    insn_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      expect_insn($sformatf("bp_i%0d", i), 64'h100 + 64'(8 * i), EXC_NONE);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (hs_log.size() > base + 4) break;
      step();
    end
    check("bp_resume_seen", 64'(hs_log.size() > base + 4), 64'd1);
    if (hs_log.size() > base + 4) check("bp_resume_addr", hs_log[base + 4], 64'h120);

    // Redirect with stale fetches in flight and an old word sitting in the queue.
    drain();
    mem_lat = 3;
    insn_ready = 1'b0;
    start_pc = 64'h100;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (insn_valid) break;
      step();
    end
    step();
    redirect_pc = 64'h200;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rd_flush_valid", 64'(insn_valid), 64'd0);
    check("rd_req_addr", imem_req_addr, 64'h200);
    insn_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      expect_insn($sformatf("rd_i%0d", i), 64'h200 + 64'(8 * i), EXC_NONE);

    // Exception response stops fetching until a redirect.
    drain();
    mem_lat = 1;
    exc_addr = 64'h118;
    start_pc = 64'h100;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++)
      expect_insn($sformatf("ex_i%0d", i), 64'h100 + 64'(8 * i), EXC_NONE);
    expect_insn("ex_fault", 64'h118, EXC_RANGE);
    repeat (2) step();
    @(negedge clk);
    #1;
    base = hs_log.size();
    repeat (8) step();
    @(negedge clk);
    #1;
    check("ex_no_new_req", 64'(hs_log.size() - base), 64'd0);
    check("ex_req_valid", 64'(imem_req_valid), 64'd0);
    check("ex_busy", 64'(busy), 64'd1);
    step();
    exc_addr = 64'h1;
    redirect_pc = 64'h300;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("ex_resume_req", 64'(imem_req_valid), 64'd1);
    check("ex_resume_addr", imem_req_addr, 64'h300);
    expect_insn("ex_resume_i0", 64'h300, EXC_NONE);

    // Stop with two fetches outstanding; ready is low in the stop cycle since stop lands at the edge.
    drain();
    mem_lat = 3;
    base = hs_log.size();
    start_pc = 64'h400;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    stop = 1'b1;
    imem_req_ready = 1'b0;
    step();
    @(negedge clk);
    check("st_busy_outstanding", 64'(busy), 64'd1);
    check("st_req_valid", 64'(imem_req_valid), 64'd0);
    step();
    imem_req_ready = 1'b1;
    expect_insn("st_i0", 64'h400, EXC_NONE);
    expect_insn("st_i1", 64'h408, EXC_NONE);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
      step();
    end
    check("st_busy_fall", 64'(busy), 64'd0);
    repeat (6) step();
    @(negedge clk);
    #1;
    check("st_req_count", 64'(hs_log.size() - base), 64'd2);
    check("st_no_extra_insn", 64'(insn_valid), 64'd0);
    step();
    stop = 1'b0;

    // Asynchronous reset mid-run, then restart; leftover responses must not surface.
    mem_lat = 3;
    insn_ready = 1'b0;
    start_pc = 64'h500;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (insn_valid) break;
      step();
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_insn_valid", 64'(insn_valid), 64'd0);
    check("ar_req_valid", 64'(imem_req_valid), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (8) step();
    @(negedge clk);
    check("ar_stale_dropped", 64'(insn_valid), 64'd0);
    step();
    insn_ready = 1'b1;
    start_pc = 64'h600;
    start = 1'b1;
    step();
    start = 1'b0;
    get_insn(pc, data, exc, ok);
    check("ar_restart_arrived", 64'(ok), 64'd1);
    check("ar_restart_pc", pc, 64'h600);
    check("ar_restart_data", data, mem_word(64'h600));
    expect_insn("ar_restart_i1", 64'h608, EXC_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
